// File: rtl/tlb_unit_pkg.sv
// Shared constants and types for the joint 16-entry MIPS32-style TLB.
package tlb_unit_pkg;

  localparam int unsigned TlbWidth    = 4;
  localparam int unsigned TlbIndexMax = 15;
  localparam int unsigned TlbEntries  = TlbIndexMax + 1;

  localparam logic [2:0] TlbOpNone = 3'd0;
  localparam logic [2:0] TlbOpWi   = 3'd1;
  localparam logic [2:0] TlbOpWr   = 3'd2;
  localparam logic [2:0] TlbOpR    = 3'd3;
  localparam logic [2:0] TlbOpP    = 3'd4;

  localparam int unsigned HiVpn2Msb = 31;
  localparam int unsigned HiVpn2Lsb = 13;
  localparam int unsigned HiAsidMsb = 7;
  localparam int unsigned LoPfnMsb  = 25;
  localparam int unsigned LoPfnLsb  = 6;
  localparam int unsigned LoCMsb    = 5;
  localparam int unsigned LoCLsb    = 3;
  localparam int unsigned LoDBit    = 2;
  localparam int unsigned LoVBit    = 1;
  localparam int unsigned LoGBit    = 0;

  localparam logic [31:0] Kseg0Base = 32'h8000_0000;
  localparam logic [31:0] Kseg1Base = 32'hA000_0000;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_half_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_half_t   lo0;
    tlb_half_t   lo1;
  } tlb_entry_t;

  // kseg0/kseg1 both alias the low 512 MB of physical memory.
  function automatic logic [31:0] unmapped_paddr(input logic [31:0] va);
    return va - (va[29] ? Kseg1Base : Kseg0Base);
  endfunction

  function automatic logic is_mapped(input logic [31:0] va);
    return va[31:30] != 2'b10;
  endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// One TLB entry's VPN2/ASID compare plus even/odd half select.
module tlb_entry_match
  import tlb_unit_pkg::*;
(
  input  tlb_entry_t  entry_i,
  input  logic [18:0] vpn2_i,
  input  logic [7:0]  asid_i,
  input  logic        odd_i,
  output logic        hit_o,
  output tlb_half_t   half_o
);

  assign hit_o  = (entry_i.vpn2 == vpn2_i) && (entry_i.g || (entry_i.asid == asid_i));
  assign half_o = odd_i ? entry_i.lo1 : entry_i.lo0;

endmodule

// File: rtl/tlb_unit.sv
// Joint 16-entry TLB: combinational inst/data translation, TLBWI/TLBWR/TLBR/TLBP handling.
module tlb_unit
  import tlb_unit_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned INDEX_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  tlb_op_i,
  input  logic [31:0] index_i,
  input  logic [31:0] random_i,
  input  logic [31:0] entryhi_i,
  input  logic [31:0] entrylo0_i,
  input  logic [31:0] entrylo1_i,
  input  logic [31:0] inst_vaddr_i,
  input  logic        inst_req_i,
  input  logic [31:0] data_vaddr_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  output logic [31:0] inst_paddr_o,
  output logic [31:0] data_paddr_o,
  output logic        inst_refill_o,
  output logic        inst_invalid_o,
  output logic        data_refill_o,
  output logic        data_invalid_o,
  output logic        data_mod_o,
  output logic        tlbr_valid_o,
  output logic [31:0] tlbr_entryhi_o,
  output logic [31:0] tlbr_entrylo0_o,
  output logic [31:0] tlbr_entrylo1_o,
  output logic        tlbp_valid_o,
  output logic [31:0] tlbp_index_o,
  output logic [7:0]  mmu_latest_asid_o
);

  tlb_entry_t entries_q [TLB_ENTRIES];

  logic [TLB_ENTRIES-1:0] inst_hit, data_hit, probe_hit;
  tlb_half_t              inst_half [TLB_ENTRIES];
  tlb_half_t              data_half [TLB_ENTRIES];
  tlb_half_t              unused_probe_half [TLB_ENTRIES];

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_entry
    tlb_entry_match u_inst (
      .entry_i(entries_q[i]),
      .vpn2_i (inst_vaddr_i[HiVpn2Msb:HiVpn2Lsb]),
      .asid_i (entryhi_i[HiAsidMsb:0]),
      .odd_i  (inst_vaddr_i[12]),
      .hit_o  (inst_hit[i]),
      .half_o (inst_half[i])
    );
    tlb_entry_match u_data (
      .entry_i(entries_q[i]),
      .vpn2_i (data_vaddr_i[HiVpn2Msb:HiVpn2Lsb]),
      .asid_i (entryhi_i[HiAsidMsb:0]),
      .odd_i  (data_vaddr_i[12]),
      .hit_o  (data_hit[i]),
      .half_o (data_half[i])
    );
    tlb_entry_match u_probe (
      .entry_i(entries_q[i]),
      .vpn2_i (entryhi_i[HiVpn2Msb:HiVpn2Lsb]),
      .asid_i (entryhi_i[HiAsidMsb:0]),
      .odd_i  (1'b0),
      .hit_o  (probe_hit[i]),
      .half_o (unused_probe_half[i])
    );
  end

  // Lowest matching index wins; multiple matches are not flagged.
  function automatic logic [INDEX_W-1:0] first_hit(input logic [TLB_ENTRIES-1:0] hits);
    logic [INDEX_W-1:0] idx;
    idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (hits[i]) idx = INDEX_W'(i);
    end
    return idx;
  endfunction

  logic [INDEX_W-1:0] inst_idx, data_idx, probe_idx;
  tlb_half_t          inst_sel, data_sel;
  logic               inst_any, data_any, inst_mapped, data_mapped;

  assign inst_idx    = first_hit(inst_hit);
  assign data_idx    = first_hit(data_hit);
  assign probe_idx   = first_hit(probe_hit);
  assign inst_sel    = inst_half[inst_idx];
  assign data_sel    = data_half[data_idx];
  assign inst_any    = |inst_hit;
  assign data_any    = |data_hit;
  assign inst_mapped = is_mapped(inst_vaddr_i);
  assign data_mapped = is_mapped(data_vaddr_i);

  always_comb begin
    inst_paddr_o = '0;
    data_paddr_o = '0;
    if (!inst_mapped)  inst_paddr_o = unmapped_paddr(inst_vaddr_i);
    else if (inst_any) inst_paddr_o = {inst_sel.pfn, inst_vaddr_i[11:0]};
    if (!data_mapped)  data_paddr_o = unmapped_paddr(data_vaddr_i);
    else if (data_any) data_paddr_o = {data_sel.pfn, data_vaddr_i[11:0]};
  end

  assign inst_refill_o  = inst_req_i & inst_mapped & ~inst_any;
  assign inst_invalid_o = inst_req_i & inst_mapped & inst_any & ~inst_sel.v;
  assign data_refill_o  = data_req_i & data_mapped & ~data_any;
  assign data_invalid_o = data_req_i & data_mapped & data_any & ~data_sel.v;
  assign data_mod_o     = data_req_i & data_mapped & data_any & data_sel.v & data_we_i & ~data_sel.d;

  logic               wr_en;
  logic [INDEX_W-1:0] wr_idx, rd_idx;
  tlb_entry_t         wr_entry_d, rd_entry;

  assign wr_en  = (tlb_op_i == TlbOpWi) || (tlb_op_i == TlbOpWr);
  assign wr_idx = (tlb_op_i == TlbOpWr) ? random_i[INDEX_W-1:0] : index_i[INDEX_W-1:0];
  assign rd_idx = index_i[INDEX_W-1:0];
  assign rd_entry = entries_q[rd_idx];

  always_comb begin
    wr_entry_d      = '0;
    wr_entry_d.vpn2 = entryhi_i[HiVpn2Msb:HiVpn2Lsb];
    wr_entry_d.asid = entryhi_i[HiAsidMsb:0];
    wr_entry_d.g    = entrylo0_i[LoGBit] & entrylo1_i[LoGBit];
    wr_entry_d.lo0  = {entrylo0_i[LoPfnMsb:LoPfnLsb], entrylo0_i[LoCMsb:LoCLsb],
                       entrylo0_i[LoDBit], entrylo0_i[LoVBit]};
    wr_entry_d.lo1  = {entrylo1_i[LoPfnMsb:LoPfnLsb], entrylo1_i[LoCMsb:LoCLsb],
                       entrylo1_i[LoDBit], entrylo1_i[LoVBit]};
  end

  logic        tlbr_valid_q, tlbp_valid_q;
  logic [31:0] tlbr_entryhi_q, tlbr_entrylo0_q, tlbr_entrylo1_q, tlbp_index_q;
  logic [7:0]  latest_asid_q;
  logic        any_flag;

  assign any_flag = data_refill_o | data_invalid_o | data_mod_o | inst_refill_o | inst_invalid_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entries_q[i] <= '0;
      tlbr_valid_q    <= 1'b0;
      tlbp_valid_q    <= 1'b0;
      tlbr_entryhi_q  <= '0;
      tlbr_entrylo0_q <= '0;
      tlbr_entrylo1_q <= '0;
      tlbp_index_q    <= '0;
      latest_asid_q   <= '0;
    end else begin
      tlbr_valid_q <= (tlb_op_i == TlbOpR);
      tlbp_valid_q <= (tlb_op_i == TlbOpP);
      if (wr_en) entries_q[wr_idx] <= wr_entry_d;
      if (tlb_op_i == TlbOpR) begin
        tlbr_entryhi_q  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
        tlbr_entrylo0_q <= {6'b0, rd_entry.lo0, rd_entry.g};
        tlbr_entrylo1_q <= {6'b0, rd_entry.lo1, rd_entry.g};
      end
      if (tlb_op_i == TlbOpP) begin
        tlbp_index_q <= (|probe_hit) ? {28'b0, probe_idx} : 32'h8000_0000;
      end
      if (any_flag) latest_asid_q <= entryhi_i[HiAsidMsb:0];
    end
  end

  // Reset in the result cycle must already hide the pending pulse and result.
  assign tlbr_valid_o      = tlbr_valid_q & ~rst;
  assign tlbp_valid_o      = tlbp_valid_q & ~rst;
  assign tlbr_entryhi_o    = rst ? '0 : tlbr_entryhi_q;
  assign tlbr_entrylo0_o   = rst ? '0 : tlbr_entrylo0_q;
  assign tlbr_entrylo1_o   = rst ? '0 : tlbr_entrylo1_q;
  assign tlbp_index_o      = rst ? '0 : tlbp_index_q;
  assign mmu_latest_asid_o = latest_asid_q;

  logic unused_bits;
  assign unused_bits = ^{index_i[31:INDEX_W], random_i[31:INDEX_W], entryhi_i[12:8],
                         entrylo0_i[31:26], entrylo1_i[31:26], inst_sel.c, inst_sel.d,
                         data_sel.c};

endmodule
